// File: rtl/timer_arbiter_if.sv
// Requester-side bundle for the shared delay timer: level requests and durations in,
// one-hot grant/done and timer status out.
interface timer_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned DUR_W = 8
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*DUR_W-1:0] dur;
  logic [N_REQ-1:0]       grant;
  logic [N_REQ-1:0]       done;
  logic                   busy;
  logic [DUR_W-1:0]       remaining;
  logic                   tick_out;

  modport master (
    output req, dur,
    input  grant, done, busy, remaining, tick_out
  );

  modport slave (
    input  req, dur,
    output grant, done, busy, remaining, tick_out
  );
endinterface

// File: rtl/timer_arbiter.sv
// Round-robin owner of one prescaled countdown timer; pulses the owner's done on expiry
// and re-arbitrates. All outputs come straight from flops.
module timer_arbiter #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned TICK_DIV = 40,
  parameter int unsigned DUR_W    = 8
) (
  input  logic           clk,
  input  logic           rst,
  timer_arbiter_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam int unsigned PRE_W = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [DUR_W-1:0] rem_q, rem_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic             busy_q, busy_d;
  logic             tick_q, tick_d;

  logic             hi_vld, lo_vld, pick_vld;
  logic [IDX_W-1:0] hi_idx, lo_idx, pick_idx;
  logic [DUR_W-1:0] pick_dur;
  logic             last_tick;

  // Round-robin pick: lowest requester above last_q wins, else lowest at or below it.
  always_comb begin
    hi_vld = 1'b0;
    hi_idx = '0;
    lo_vld = 1'b0;
    lo_idx = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (bus.req[j]) begin
        if (IDX_W'(j) > last_q) begin
          hi_vld = 1'b1;
          hi_idx = IDX_W'(j);
        end else begin
          lo_vld = 1'b1;
          lo_idx = IDX_W'(j);
        end
      end
    end
    pick_vld = hi_vld | lo_vld;
    pick_idx = hi_vld ? hi_idx : lo_idx;
    pick_dur = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (IDX_W'(j) == pick_idx) pick_dur = bus.dur[j*DUR_W +: DUR_W];
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    pre_d     = pre_q;
    rem_d     = rem_q;
    grant_d   = '0;
    done_d    = '0;
    busy_d    = 1'b0;
    tick_d    = 1'b0;
    last_tick = (pre_q == PRE_MAX) && (rem_q == DUR_W'(1));

    unique case (state_q)
      S_IDLE: begin
        pre_d = '0;
        if (pick_vld) begin
          owner_d = pick_idx;
          rem_d   = pick_dur;
          if (pick_dur != '0) begin
            state_d = S_RUN;
            grant_d = N_REQ'(1) << pick_idx;
            busy_d  = 1'b1;
          end else begin
            state_d = S_DONE;
            done_d  = N_REQ'(1) << pick_idx;
          end
        end
      end

      S_RUN: begin
        if (pre_q == PRE_MAX) begin
          pre_d = '0;
          rem_d = rem_q - DUR_W'(1);
        end else begin
          pre_d = pre_q + PRE_W'(1);
        end
        // Expiry outranks a cancel landing on the same edge.
        if (last_tick) begin
          state_d = S_DONE;
          done_d  = N_REQ'(1) << owner_q;
        end else if (!bus.req[owner_q]) begin
          state_d = S_IDLE;
          last_d  = owner_q;
          rem_d   = '0;
          pre_d   = '0;
        end else begin
          grant_d = N_REQ'(1) << owner_q;
          busy_d  = 1'b1;
          tick_d  = (pre_d == PRE_MAX);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        last_d  = owner_q;
        rem_d   = '0;
        pre_d   = '0;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      last_q  <= IDX_W'(N_REQ - 1);
      pre_q   <= '0;
      rem_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      pre_q   <= pre_d;
      rem_q   <= rem_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      tick_q  <= tick_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;
  assign bus.remaining = rem_q;
  assign bus.tick_out  = tick_q;
endmodule
